// File: rtl/tmc_rx_fifo_reader.sv
// -----------------------------------------------------------------------------
// tmc_rx_fifo_reader
//
// Avalon-MM slave (Nios side) that pops one word from the RX FIFO on request
// and holds it in a data register until the CPU reads it.
// A fetch is requested by a rising edge on rd_strobe_in (PIO level) or by
// writing 1 to CONTROL bit0. Each fetch runs IDLE -> POP -> WAIT -> CAPT.
//
// Register map (readdata is combinational, 0 when chipselect=0):
//   0 DATA    : zero-extended data_reg; a read clears valid
//   1 STATUS  : [0] valid [1] busy [2] fifo_empty [3] underflow [4] dropped
//               [31:16] fifo_usedw; write 1 to bit3/bit4 to clear them
//   2 CONTROL : [0] fetch (write-only, reads 0) [1] irq_enable (IRQ build)
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   address, chipselect, read,
//   write_n, writedata         Avalon-MM slave inputs
//   readdata                   Avalon-MM read data, zero wait states
//   rd_strobe_in               PIO fetch strobe, already in the clk domain
//   fifo_rdreq                 FIFO pop, one-cycle pulse
//   fifo_q, fifo_empty,
//   fifo_usedw                 FIFO read-side status/data
//   irq                        interrupt, only with RX_FIFO_READER_IRQ_EN
//
// Build option: define RX_FIFO_READER_IRQ_EN to add the irq port and the
// CONTROL bit1 irq_enable flop.
//
// A reset taken in POP or WAIT drops fifo_rdreq immediately; a word already
// popped from the FIFO is lost.
// -----------------------------------------------------------------------------
module tmc_rx_fifo_reader #(
  parameter int DATA_W   = 32,
  parameter int USEDW_W  = 10,
  parameter int FIFO_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic               rd_strobe_in,
  output logic               fifo_rdreq,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw
`ifdef RX_FIFO_READER_IRQ_EN
  ,
  output logic               irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_CAPT = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // WAIT lasts FIFO_LAT cycles counted down from FIFO_LAT-1 (max 3).
  localparam logic [1:0] LAT_LOAD = 2'(FIFO_LAT - 1);

  state_t            state, state_next;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] data_reg;
  logic              valid;
  logic              underflow;
  logic              dropped;
  logic              strobe_d;

  logic              wr_en;
  logic              rd_en;
  logic              strobe_rise;
  logic              ctrl_fetch;
  logic              fetch_req;
  logic              rdreq_c;
  logic              capture;
  logic              underflow_set;
  logic              dropped_set;
  logic              underflow_clr;
  logic              dropped_clr;
  logic              data_read;

  logic [31:0]       data_ext;
  logic [31:0]       status_word;
  logic [31:0]       ctrl_word;

  // Write-data bits that no register uses.
  logic              unused_wdata;
  assign unused_wdata = ^{writedata[31:5], writedata[2:1]};

  // ---------------------------------------------------------------------------
  // Bus decode and fetch request
  // ---------------------------------------------------------------------------
  assign wr_en       = chipselect & ~write_n;
  assign rd_en       = chipselect & read;
  assign strobe_rise = rd_strobe_in & ~strobe_d;
  assign ctrl_fetch  = wr_en & (address == ADDR_CTRL) & writedata[0];
  // A PIO edge and a CONTROL write in the same cycle merge into one request.
  assign fetch_req   = strobe_rise | ctrl_fetch;

  assign underflow_clr = wr_en & (address == ADDR_STATUS) & writedata[3];
  assign dropped_clr   = wr_en & (address == ADDR_STATUS) & writedata[4];
  assign data_read     = rd_en & (address == ADDR_DATA);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments (<=) so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and per-state strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    rdreq_c       = 1'b0;
    capture       = 1'b0;
    underflow_set = 1'b0;
    dropped_set   = 1'b0;

    case (state)
      S_IDLE: begin
        if (fetch_req) begin
          if (fifo_empty) begin
            underflow_set = 1'b1;
          end else begin
            state_next = S_POP;
          end
        end
      end
      S_POP: begin
        rdreq_c    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_next = S_CAPT;
        end
      end
      S_CAPT: begin
        capture    = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Requests arriving mid-fetch are not queued; they only flag the loss.
    if (fetch_req && (state != S_IDLE)) begin
      dropped_set = 1'b1;
    end
  end

  // Decoded straight from the state register so an asynchronous reset in
  // POP removes the pop request at once.
  assign fifo_rdreq = rdreq_c;

  // ---------------------------------------------------------------------------
  // FIFO latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 2'd0;
    end else if (state == S_POP) begin
      wait_cnt <= LAT_LOAD;
    end else if ((state == S_WAIT) && (wait_cnt != 2'd0)) begin
      wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe edge detector, data register and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_d  <= 1'b0;
      data_reg  <= '0;
      valid     <= 1'b0;
      underflow <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      strobe_d <= rd_strobe_in;

      if (capture) begin
        data_reg <= fifo_q;
      end

      // Capture outranks a concurrent DATA read: the fresh word stays valid.
      if (capture) begin
        valid <= 1'b1;
      end else if (data_read) begin
        valid <= 1'b0;
      end

      // Sticky flags: a set in the same cycle as its clear wins.
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end

      if (dropped_set) begin
        dropped <= 1'b1;
      end else if (dropped_clr) begin
        dropped <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional interrupt
  // ---------------------------------------------------------------------------
`ifdef RX_FIFO_READER_IRQ_EN
  logic irq_enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_CTRL)) begin
        irq_enable <= writedata[1];
      end
      irq <= irq_enable & (valid | underflow | dropped);
    end
  end

  always_comb begin
    ctrl_word    = 32'd0;
    ctrl_word[1] = irq_enable;
  end
`else
  assign ctrl_word = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    data_ext               = 32'd0;
    data_ext[DATA_W-1:0]   = data_reg;

    status_word                  = 32'd0;
    status_word[0]               = valid;
    status_word[1]               = (state != S_IDLE);
    status_word[2]               = fifo_empty;
    status_word[3]               = underflow;
    status_word[4]               = dropped;
    status_word[16 +: USEDW_W]   = fifo_usedw;
  end

  always_comb begin
    readdata = 32'd0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:   readdata = data_ext;
        ADDR_STATUS: readdata = status_word;
        ADDR_CTRL:   readdata = ctrl_word;
        default:     readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_tmc_rx_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_tmc_rx_fifo_reader
//
// Directed bench for tmc_rx_fifo_reader (DATA_W=32, USEDW_W=10, FIFO_LAT=1).
// A small registered-output FIFO model feeds the DUT; stimulus is driven and
// outputs sampled on the falling clock edge. Expected values are hand-derived
// from the register map and the 3-cycle fetch latency.
// -----------------------------------------------------------------------------
module tb_tmc_rx_fifo_reader;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rd_strobe_in;
  logic        fifo_rdreq;
  logic [31:0] fifo_q;
  logic        fifo_empty;
  logic [9:0]  fifo_usedw;
`ifdef RX_FIFO_READER_IRQ_EN
  logic        irq;
`endif

  int compared   = 0;
  int mismatched = 0;

  // FIFO model: registered output, one-cycle read latency.
  logic [31:0] mem [16];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rdreq_cnt = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_usedw = 10'(wr_ptr - rd_ptr);

  initial fifo_q = 32'd0;

  always @(posedge clk) begin
    if (fifo_rdreq && (wr_ptr != rd_ptr)) begin
      fifo_q <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (fifo_rdreq) rdreq_cnt <= rdreq_cnt + 1;
  end

  tmc_rx_fifo_reader #(
    .DATA_W  (32),
    .USEDW_W (10),
    .FIFO_LAT(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .read        (read),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .rd_strobe_in(rd_strobe_in),
    .fifo_rdreq  (fifo_rdreq),
    .fifo_q      (fifo_q),
    .fifo_empty  (fifo_empty),
    .fifo_usedw  (fifo_usedw)
`ifdef RX_FIFO_READER_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] word);
    mem[wr_ptr % 16] = word;
    wr_ptr = wr_ptr + 1;
  endtask

  // Look at a register without a read strobe (no side effects).
  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    chipselect = 1'b1;
    read       = 1'b0;
    address    = a;
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] v);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    #1;
    v = readdata;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  initial begin
    logic [31:0] v;
    int          cnt0;

    reset_n      = 1'b0;
    address      = 2'd0;
    chipselect   = 1'b0;
    read         = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'd0;
    rd_strobe_in = 1'b0;
    push(32'hA5A5_0001);
    push(32'h0000_0002);

    // Reset state
    tick();
    tick();
    check("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    peek(2'd0, v);
    check("rst_data", v, 32'd0);
    reset_n = 1'b1;
    tick();
    peek(2'd1, v);
    check("rst_status", v, 32'h0002_0000);
    chipselect = 1'b0;
    address    = 2'd1;
    #1;
    check("cs_low_reads_0", readdata, 32'd0);

    // PIO strobe fetch: POP, WAIT, CAPT, then valid
    rd_strobe_in = 1'b1;
    tick();
    check("strobe_pop_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    peek(2'd1, v);
    check("strobe_pop_status", v, 32'h0002_0002);
    tick();
    check("strobe_wait_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    peek(2'd1, v);
    check("strobe_wait_status", v, 32'h0001_0002);
    tick();
    peek(2'd1, v);
    check("strobe_capt_status", v, 32'h0001_0002);
    tick();
    peek(2'd1, v);
    check("strobe_valid_status", v, 32'h0001_0001);
    check("strobe_rdreq_count", 32'(rdreq_cnt), 32'd1);
    av_read(2'd0, v);
    check("strobe_data", v, 32'hA5A5_0001);
    peek(2'd1, v);
    check("strobe_valid_cleared", v, 32'h0001_0000);
    check("strobe_level_no_refetch", 32'(rdreq_cnt), 32'd1);
    rd_strobe_in = 1'b0;

    // CONTROL fetch of the last word
    av_write(2'd2, 32'h1);
    tick();
    tick();
    tick();
    peek(2'd1, v);
    check("ctrl_status", v, 32'h0000_0005);
    av_read(2'd0, v);
    check("ctrl_data", v, 32'h0000_0002);
    peek(2'd2, v);
    check("ctrl_selfclear", v, 32'd0);

    // Fetch from an empty FIFO: no pop, underflow set
    cnt0 = rdreq_cnt;
    av_write(2'd2, 32'h1);
    tick();
    tick();
    tick();
    check("underflow_no_rdreq", 32'(rdreq_cnt), 32'(cnt0));
    peek(2'd1, v);
    check("underflow_status", v, 32'h0000_000C);

    // Clear stickies, then a dropped second request during POP
    push(32'h0000_0033);
    push(32'h0000_0044);
    av_write(2'd1, 32'h18);
    peek(2'd1, v);
    check("w1c_status", v, 32'h0002_0000);
    cnt0 = rdreq_cnt;
    av_write(2'd2, 32'h1);
    av_write(2'd2, 32'h1);
    tick();
    tick();
    peek(2'd1, v);
    check("dropped_status", v, 32'h0001_0011);
    check("dropped_one_rdreq", 32'(rdreq_cnt - cnt0), 32'd1);
    av_read(2'd0, v);
    check("dropped_data", v, 32'h0000_0033);
    av_write(2'd1, 32'h10);
    peek(2'd1, v);
    check("dropped_cleared", v, 32'h0001_0000);

    // Reset while in WAIT
    av_write(2'd2, 32'h1);
    tick();
    peek(2'd1, v);
    check("wait_busy", v, 32'h0000_0006);
    reset_n = 1'b0;
    #1;
    check("wait_rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    peek(2'd0, v);
    check("wait_rst_data", v, 32'd0);
    peek(2'd1, v);
    check("wait_rst_status", v, 32'h0000_0004);

    // Reset while in POP: rdreq must drop without waiting for a clock
    push(32'h0000_0055);
    av_write(2'd2, 32'h1);
    check("pop_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("pop_rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    peek(2'd1, v);
    check("pop_rst_status", v, 32'h0001_0000);

`ifdef RX_FIFO_READER_IRQ_EN
    av_write(2'd2, 32'h2);
    peek(2'd2, v);
    check("irq_enable_read", v, 32'h2);
    rd_strobe_in = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    rd_strobe_in = 1'b0;
    av_read(2'd0, v);
    check("irq_data", v, 32'h0000_0055);
    tick();
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    av_write(2'd2, 32'h2);
    peek(2'd2, v);
    check("ctrl_bit1_absent", v, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
